// File: rtl/pipe_pkg.sv
// Shared types for the pipeline register stages: handshake FSM state encoding
// and the statistics counter width.
package pipe_pkg;

    typedef enum logic [1:0] {
        PS_EMPTY = 2'b00,
        PS_BUSY  = 2'b01,
        PS_FULL  = 2'b10
    } pipe_state_t;

    localparam int STAT_W = 16;

endpackage : pipe_pkg

// File: rtl/pipe_sat_counter.sv
// Saturating up-counter used for the pipeline stage statistics.
// Counts once per cycle with inc=1, holds at all-ones, clears only on rst_n.
module pipe_sat_counter
    import pipe_pkg::*;
#(
    parameter int WIDTH = STAT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (inc && (count_q != {WIDTH{1'b1}})) begin
            count_d = count_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule : pipe_sat_counter

// File: rtl/pipe_stage_skid.sv
// Valid/ready pipeline register stage with a 2-entry skid buffer and flush.
// Define PIPE_STAGE_STATS_EN to add the stall_cnt / flush_cnt statistics ports.
module pipe_stage_skid
    import pipe_pkg::*;
#(
    parameter int               WIDTH  = 16,
    parameter logic [WIDTH-1:0] BUBBLE = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WIDTH-1:0]  in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WIDTH-1:0]  out_data,
    output logic [1:0]        occupancy
`ifdef PIPE_STAGE_STATS_EN
    ,
    output logic [STAT_W-1:0] stall_cnt,
    output logic [STAT_W-1:0] flush_cnt
`endif
);

    pipe_state_t      state_q;
    pipe_state_t      state_d;
    logic [WIDTH-1:0] main_q;
    logic [WIDTH-1:0] main_d;
    logic [WIDTH-1:0] skid_q;
    logic [WIDTH-1:0] skid_d;
    logic             acc;
    logic             dq;

    // Ready depends on registered state only, so no ready path ripples upstream.
    assign in_ready  = (state_q != PS_FULL);
    assign out_valid = (state_q != PS_EMPTY);
    assign out_data  = out_valid ? main_q : BUBBLE;

    assign acc = in_valid & in_ready;
    assign dq  = out_valid & out_ready;

    always_comb begin
        occupancy = 2'd0;
        case (state_q)
            PS_BUSY: occupancy = 2'd1;
            PS_FULL: occupancy = 2'd2;
            default: occupancy = 2'd0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush) begin
            // Squash everything; an offered input is dropped, a dq completes as usual.
            state_d = PS_EMPTY;
        end else begin
            case (state_q)
                PS_EMPTY: begin
                    if (acc) begin
                        state_d = PS_BUSY;
                        main_d  = in_data;
                    end
                end
                PS_BUSY: begin
                    if (acc && dq) begin
                        main_d = in_data;
                    end else if (acc) begin
                        state_d = PS_FULL;
                        skid_d  = in_data;
                    end else if (dq) begin
                        state_d = PS_EMPTY;
                    end
                end
                PS_FULL: begin
                    if (dq) begin
                        state_d = PS_BUSY;
                        main_d  = skid_q;
                    end
                end
                default: state_d = PS_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= PS_EMPTY;
            main_q  <= BUBBLE;
            skid_q  <= BUBBLE;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end

`ifdef PIPE_STAGE_STATS_EN
    logic stall_inc;
    logic flush_inc;

    assign stall_inc = out_valid & ~out_ready;
    assign flush_inc = flush & (state_q != PS_EMPTY);

    pipe_sat_counter #(.WIDTH(STAT_W)) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (stall_inc),
        .count (stall_cnt)
    );

    pipe_sat_counter #(.WIDTH(STAT_W)) u_flush_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (flush_inc),
        .count (flush_cnt)
    );
`endif

endmodule : pipe_stage_skid

// File: tb/tb_pipe_stage_skid.sv
// Directed self-checking bench for pipe_stage_skid (statistics checks run when
// PIPE_STAGE_STATS_EN is defined).
module tb_pipe_stage_skid;

    localparam int               WIDTH  = 16;
    localparam logic [WIDTH-1:0] BUBBLE = 16'h0BAD;

    logic             clk;
    logic             rst_n;
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [1:0]       occupancy;
`ifdef PIPE_STAGE_STATS_EN
    logic [15:0]      stall_cnt;
    logic [15:0]      flush_cnt;
`endif

    int n_cmp = 0;
    int n_err = 0;

    pipe_stage_skid #(.WIDTH(WIDTH), .BUBBLE(BUBBLE)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .occupancy (occupancy)
`ifdef PIPE_STAGE_STATS_EN
        ,
        .stall_cnt (stall_cnt),
        .flush_cnt (flush_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one edge; outputs are sampled 1 time unit after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_valid"}, 32'(out_valid), 32'd0);
        chk({tag, "_ready"}, 32'(in_ready), 32'd1);
        chk({tag, "_data"}, 32'(out_data), 32'(BUBBLE));
        chk({tag, "_occ"}, 32'(occupancy), 32'd0);
    endtask

    initial begin
        rst_n     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;

        // Reset
        tick();
        tick();
        chk_idle("rst");
`ifdef PIPE_STAGE_STATS_EN
        chk("rst_stall_cnt", 32'(stall_cnt), 32'd0);
        chk("rst_flush_cnt", 32'(flush_cnt), 32'd0);
`endif
        rst_n = 1'b1;

        // Streaming 1..16 with no gaps
        out_ready = 1'b1;
        in_valid  = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            in_data = 16'(i);
            tick();
            chk("stream_valid", 32'(out_valid), 32'd1);
            chk("stream_data", 32'(out_data), 32'(i));
            chk("stream_ready", 32'(in_ready), 32'd1);
            chk("stream_occ", 32'(occupancy), 32'd1);
        end
        in_valid = 1'b0;
        tick();
        chk_idle("stream_drain");

        // Stall and skid
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 16'h00A1;
        tick();
        chk("skid_occ1", 32'(occupancy), 32'd1);
        chk("skid_head1", 32'(out_data), 32'h00A1);
        in_data = 16'h00A2;
        tick();
        chk("skid_occ2", 32'(occupancy), 32'd2);
        chk("skid_ready0", 32'(in_ready), 32'd0);
        chk("skid_head_full", 32'(out_data), 32'h00A1);
        in_data = 16'h00FF;
        tick();
        chk("skid_hold_occ", 32'(occupancy), 32'd2);
        chk("skid_hold_head", 32'(out_data), 32'h00A1);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        chk("skid_second", 32'(out_data), 32'h00A2);
        chk("skid_ready1", 32'(in_ready), 32'd1);
        chk("skid_occ_after", 32'(occupancy), 32'd1);
        tick();
        chk_idle("skid_drain");

        // Flush in FULL with an input offered
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 16'h00D1;
        tick();
        in_data = 16'h00D2;
        tick();
        chk("fl_full_occ", 32'(occupancy), 32'd2);
        flush   = 1'b1;
        in_data = 16'h00B3;
        tick();
        chk_idle("fl_full");
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        chk("fl_full_no_b3", 32'(out_valid), 32'd0);
        chk("fl_full_no_b3_data", 32'(out_data), 32'(BUBBLE));

        // Flush together with dq in BUSY
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 16'h00C4;
        tick();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        flush     = 1'b1;
        chk("fl_dq_head", 32'(out_data), 32'h00C4);
        chk("fl_dq_valid", 32'(out_valid), 32'd1);
        tick();
        chk_idle("fl_dq");
        flush = 1'b0;
        tick();
        chk("fl_dq_once", 32'(out_valid), 32'd0);

        // Flush while EMPTY drops the handshaking input
        in_valid = 1'b1;
        in_data  = 16'h00E1;
        flush    = 1'b1;
        chk("fl_empty_ready", 32'(in_ready), 32'd1);
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        chk_idle("fl_empty");

        // Async reset mid-FULL, then accept immediately after release
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 16'h0011;
        tick();
        in_data = 16'h0022;
        tick();
        chk("arst_pre_occ", 32'(occupancy), 32'd2);
        #2;
        rst_n = 1'b0;
        #1;
        chk_idle("arst");
        @(negedge clk);
        rst_n     = 1'b1;
        in_valid  = 1'b1;
        in_data   = 16'h00E5;
        out_ready = 1'b1;
        tick();
        chk("arst_accept", 32'(out_data), 32'h00E5);
        chk("arst_accept_valid", 32'(out_valid), 32'd1);
        in_valid = 1'b0;
        tick();
        chk_idle("arst_drain");

`ifdef PIPE_STAGE_STATS_EN
        // Statistics: saturating stall count, flushes only on non-empty
        rst_n = 1'b0;
        tick();
        rst_n     = 1'b1;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 16'h0055;
        tick();
        in_valid = 1'b0;
        tick();
        chk("st_stall_small", 32'(stall_cnt), 32'd1);
        for (int i = 0; i < 70000; i++) begin
            @(posedge clk);
        end
        #1;
        chk("st_stall_sat", 32'(stall_cnt), 32'hFFFF);
        for (int k = 0; k < 3; k++) begin
            flush = 1'b1;
            tick();
            flush    = 1'b0;
            in_valid = 1'b1;
            tick();
            in_valid = 1'b0;
        end
        chk("st_flush3", 32'(flush_cnt), 32'd3);
        flush = 1'b1;
        tick();
        chk("st_flush_busy4", 32'(flush_cnt), 32'd4);
        tick();
        flush = 1'b0;
        chk("st_flush_empty", 32'(flush_cnt), 32'd4);
        chk("st_stall_hold", 32'(stall_cnt), 32'hFFFF);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_pipe_stage_skid
